// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C master/slave pair
package i2c_pkg;
   typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, LOAD, DATA, DATA_ACK, STOP} state_e;
   typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_e;
   localparam logic RW_WRITE = 1'b0;
   localparam logic [6:0] DEFAULT_DEVICE_ADDR = 7'b1000111;
endpackage

// File: rtl/i2c_phase_gen.sv
// i2c_phase_gen: quarter-period counter giving the SCL bit phase and a quarter-end strobe
module i2c_phase_gen
   import i2c_pkg::*;
#(
   parameter int QTR_CYCLES = 125,
   parameter int CNT_W = $clog2(QTR_CYCLES)
) (
   input  logic   i_clk,
   input  logic   w_start_rst,
   input  logic   i_en,
   output phase_e o_phase,
   output logic   o_phase_end
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   phase_e phase_q, phase_d;
   always_ff @(posedge i_clk or posedge w_start_rst)
      if (w_start_rst) begin
         cnt_q <= '0;
         phase_q <= Q0;
      end else begin
         cnt_q <= cnt_d;
         phase_q <= phase_d;
      end
   always_comb begin
      o_phase_end = i_en && cnt_q == CNT_W'(QTR_CYCLES - 1);
      cnt_d = (!i_en || o_phase_end) ? '0 : cnt_q + CNT_W'(1);
      phase_d = !i_en ? Q0 : o_phase_end ? phase_e'(phase_q + 2'd1) : phase_q;
   end
   assign o_phase = phase_q;
endmodule

// File: rtl/i2c_master_tx.sv
// i2c_master_tx: write-only I2C master serialising a valid/ready byte stream to one addressed slave
module i2c_master_tx
   import i2c_pkg::*;
#(
   parameter int QTR_CYCLES = 125,
   parameter int CNT_W = $clog2(QTR_CYCLES)
) (
   input  logic       i_clk,
   input  logic       w_start_rst,
   input  logic       i_start,
   input  logic [6:0] i_addr,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_last,
   input  logic       i_tx_valid,
   output logic       o_tx_ready,
   input  logic       i_sda_in,
   output logic       o_scl_oe,
   output logic       o_sda_oe,
   output logic       o_busy,
   output logic       o_nack,
   output logic       o_done
);
   state_e state_q, state_d;
   phase_e phase;
   logic phase_end, bit_end, sample;
   logic [2:0] bit_q, bit_d;
   logic [6:0] addr_q, addr_d;
   logic [7:0] data_q, data_d, tx_byte;
   logic last_q, last_d, nack_q, nack_d;
   i2c_phase_gen #(.QTR_CYCLES(QTR_CYCLES), .CNT_W(CNT_W)) u_phase (
      .i_clk(i_clk),
      .w_start_rst(w_start_rst),
      .i_en(state_q != IDLE && state_q != LOAD),
      .o_phase(phase),
      .o_phase_end(phase_end)
   );
   assign bit_end = phase_end && phase == Q3;
   assign sample = phase_end && phase == Q2;
   assign tx_byte = state_q == ADDR ? {addr_q, RW_WRITE} : data_q;
   always_ff @(posedge i_clk or posedge w_start_rst)
      if (w_start_rst) begin
         state_q <= IDLE;
         bit_q <= 3'd7;
         addr_q <= '0;
         data_q <= '0;
         last_q <= 1'b0;
         nack_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q <= bit_d;
         addr_q <= addr_d;
         data_q <= data_d;
         last_q <= last_d;
         nack_q <= nack_d;
      end
   // bit counter wraps 0->7 exactly on the slot that leaves ADDR/DATA
   always_comb begin
      state_d = state_q;
      bit_d = (bit_end && (state_q == ADDR || state_q == DATA)) ? bit_q - 3'd1 : bit_q;
      addr_d = addr_q;
      data_d = data_q;
      last_d = last_q;
      nack_d = nack_q;
      case (state_q)
         IDLE:
            if (i_start) begin
               state_d = START;
               addr_d = i_addr;
               nack_d = 1'b0;
            end
         START: if (bit_end) state_d = ADDR;
         ADDR: if (bit_end && bit_q == 3'd0) state_d = ADDR_ACK;
         ADDR_ACK, DATA_ACK: begin
            if (sample && i_sda_in) nack_d = 1'b1;
            if (bit_end) state_d = (nack_q || (state_q == DATA_ACK && last_q)) ? STOP : LOAD;
         end
         LOAD:
            if (i_tx_valid) begin
               state_d = DATA;
               data_d = i_tx_data;
               last_d = i_tx_last;
            end
         DATA: if (bit_end && bit_q == 3'd0) state_d = DATA_ACK;
         STOP: if (bit_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      o_scl_oe = 1'b0;
      o_sda_oe = 1'b0;
      case (state_q)
         START: begin
            o_scl_oe = phase == Q3;
            o_sda_oe = phase == Q2 || phase == Q3;
         end
         ADDR, DATA: begin
            o_scl_oe = phase == Q0 || phase == Q1;
            o_sda_oe = !tx_byte[bit_q];
         end
         ADDR_ACK, DATA_ACK: o_scl_oe = phase == Q0 || phase == Q1;
         LOAD: o_scl_oe = 1'b1;
         STOP: begin
            o_scl_oe = phase == Q0;
            o_sda_oe = phase != Q3;
         end
         default: ;
      endcase
   end
   assign o_tx_ready = state_q == LOAD;
   assign o_busy = state_q != IDLE;
   assign o_nack = nack_q;
   assign o_done = state_q == STOP && bit_end;
endmodule

// File: tb/tb_i2c_master_tx.sv
// tb_i2c_master_tx: randomized scoreboard bench decoding the I2C bus against a transaction-level model
module tb_i2c_master_tx;
   import i2c_pkg::*;
   localparam int QTR = 4;
   localparam int EV_STOP = 256;
   localparam int EV_START = 257;
   logic i_clk = 1'b0;
   logic w_start_rst = 1'b1;
   logic i_start = 1'b0;
   logic [6:0] i_addr = '0;
   logic [7:0] i_tx_data = '0;
   logic i_tx_last = 1'b0;
   logic i_tx_valid = 1'b0;
   logic o_tx_ready, o_scl_oe, o_sda_oe, o_busy, o_nack, o_done, i_sda_in;
   logic slave_pull = 1'b0;
   logic [6:0] slave_addr = DEFAULT_DEVICE_ADDR;
   int n_chk = 0, n_pass = 0, cyc = 0;
   int exp_q[$];
   bit exp_done_q[$];
   bit mon_en = 1'b1;
   int nack_plan = -1, pulse_g = 0;
   int nbits = 0, bidx = 0, rise_t = 0, ld_scl_hi = 0, ready_seen = 0;
   bit in_frame = 1'b0, rise_ok = 1'b0, ack_dec = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1;
   logic [7:0] sh = '0;

   i2c_master_tx #(.QTR_CYCLES(QTR)) dut (
      .i_clk(i_clk), .w_start_rst(w_start_rst), .i_start(i_start), .i_addr(i_addr),
      .i_tx_data(i_tx_data), .i_tx_last(i_tx_last), .i_tx_valid(i_tx_valid),
      .o_tx_ready(o_tx_ready), .i_sda_in(i_sda_in), .o_scl_oe(o_scl_oe),
      .o_sda_oe(o_sda_oe), .o_busy(o_busy), .o_nack(o_nack), .o_done(o_done)
   );

   assign i_sda_in = !(o_sda_oe || slave_pull);
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
   endtask

   task automatic got(input int v);
      if (exp_q.size() == 0) chk("bus_event_unexpected", v, -1);
      else chk("bus_event", v, exp_q.pop_front());
   endtask

   // bus monitor plus slave model: decodes START/bytes/STOP, drives ACK, checks SCL high time
   initial begin
      bit scl, sda;
      forever begin
         @(negedge i_clk);
         scl = !o_scl_oe;
         sda = i_sda_in;
         if (!mon_en) begin
            in_frame = 1'b0;
            rise_ok = 1'b0;
            nbits = 0;
            bidx = 0;
            slave_pull = 1'b0;
         end else begin
            if (o_tx_ready) ready_seen++;
            if (o_tx_ready && scl) ld_scl_hi++;
            if (o_done) begin
               if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0);
               else chk("nack_at_done", int'(o_nack), int'(exp_done_q.pop_front()));
            end
            if (scl && prev_scl && prev_sda && !sda) begin
               in_frame = 1'b1;
               nbits = 0;
               bidx = 0;
               rise_ok = 1'b0;
               got(EV_START);
            end else if (scl && prev_scl && !prev_sda && sda && in_frame) begin
               in_frame = 1'b0;
               rise_ok = 1'b0;
               got(EV_STOP);
            end
            if (scl && !prev_scl) begin
               rise_t = cyc;
               rise_ok = in_frame;
               if (in_frame && nbits == 8) nbits = 0;
               else if (in_frame) begin
                  sh = {sh[6:0], sda};
                  nbits++;
                  if (nbits == 8) begin
                     got(int'(sh));
                     ack_dec = (bidx == 0) ? (sh[7:1] == slave_addr) : (bidx - 1 != nack_plan);
                     bidx++;
                  end
               end
            end
            if (!scl && prev_scl) begin
               if (rise_ok) chk("scl_high_clocks", cyc - rise_t, 2 * QTR);
               rise_ok = 1'b0;
               slave_pull = in_frame && nbits == 8 && ack_dec;
            end
         end
         prev_scl = scl;
         prev_sda = sda;
      end
   end

   function automatic int model(input logic [6:0] a, input int n, input logic [7:0] d [4], input int nk);
      exp_q.push_back(EV_START);
      exp_q.push_back(int'({a, RW_WRITE}));
      if (a != slave_addr) begin
         exp_q.push_back(EV_STOP);
         exp_done_q.push_back(1'b1);
         return 0;
      end
      for (int k = 0; k < n; k++) begin
         exp_q.push_back(int'(d[k]));
         if (k == nk) begin
            exp_q.push_back(EV_STOP);
            exp_done_q.push_back(1'b1);
            return k + 1;
         end
      end
      exp_q.push_back(EV_STOP);
      exp_done_q.push_back(1'b0);
      return n;
   endfunction

   task automatic start_txn(input logic [6:0] a);
      @(negedge i_clk);
      i_addr = a;
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input bit l, input int dly, output bit took);
      took = 1'b0;
      for (int t = 0; t < 3000 && !o_tx_ready && o_busy; t++) @(negedge i_clk);
      repeat (dly) @(negedge i_clk);
      i_tx_data = d;
      i_tx_last = l;
      i_tx_valid = 1'b1;
      for (int t = 0; t < 3000; t++) begin
         if (o_tx_ready) begin
            took = 1'b1;
            break;
         end
         if (!o_busy && t >= 10) break;
         @(negedge i_clk);
      end
      if (!took && o_busy) chk("handshake_timeout", 0, 1);
      @(negedge i_clk);
      i_tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 5000 && o_busy; t++) @(negedge i_clk);
      chk("busy_timeout", int'(o_busy), 0);
      repeat (3) @(negedge i_clk);
   endtask

   task automatic run_txn(input logic [6:0] a, input int n, input logic [7:0] d [4], input int nk,
                          input int dl [4], input int pulse_at);
      int took_n, exp_took;
      bit took;
      took_n = 0;
      nack_plan = nk;
      pulse_g = pulse_at;
      exp_took = model(a, n, d, nk);
      start_txn(a);
      if (pulse_g > 0)
         fork
            begin
               repeat (pulse_g) @(negedge i_clk);
               i_start = 1'b1;
               @(negedge i_clk);
               i_start = 1'b0;
            end
         join_none
      for (int k = 0; k < n; k++) begin
         send_byte(d[k], k == n - 1, dl[k], took);
         took_n += int'(took);
      end
      wait_idle();
      chk("bytes_consumed", took_n, exp_took);
      chk("events_pending", exp_q.size(), 0);
      chk("done_pending", exp_done_q.size(), 0);
   endtask

   initial begin
      logic [7:0] d [4];
      int dl [4];
      int act, snap, n, nk;
      bit took;
      logic [6:0] a;
      repeat (5) @(negedge i_clk);
      chk("reset_outputs", int'({o_scl_oe, o_sda_oe, o_busy, o_tx_ready, o_nack, o_done}), 0);
      w_start_rst = 1'b0;
      act = 0;
      repeat (1000) begin
         @(negedge i_clk);
         act += int'(o_scl_oe | o_sda_oe | o_busy | o_tx_ready | o_done | o_nack);
      end
      chk("idle_activity", act, 0);
      d = '{8'hA5, 8'h00, 8'h00, 8'h00};
      dl = '{0, 0, 0, 0};
      run_txn(7'h47, 1, d, -1, dl, 0);
      chk("t2_nack", int'(o_nack), 0);
      snap = ready_seen;
      run_txn(7'h12, 1, d, -1, dl, 0);
      chk("t3_ready_never", ready_seen - snap, 0);
      chk("t3_nack", int'(o_nack), 1);
      snap = ready_seen;
      act = ld_scl_hi;
      d = '{8'h3C, 8'hC3, 8'h00, 8'h00};
      dl = '{0, 37, 0, 0};
      run_txn(7'h47, 2, d, -1, dl, 0);
      chk("t4_load_wait", int'(ready_seen - snap >= 38), 1);
      chk("t4_scl_low_in_load", ld_scl_hi - act, 0);
      d = '{8'h11, 8'h22, 8'h33, 8'h00};
      dl = '{0, 0, 0, 0};
      run_txn(7'h47, 3, d, 0, dl, 13 * 4 * QTR);
      chk("t5_nack", int'(o_nack), 1);
      nack_plan = -1;
      exp_q.push_back(EV_START);
      exp_q.push_back(int'({7'h47, RW_WRITE}));
      start_txn(7'h47);
      send_byte(8'h5A, 1'b0, 0, took);
      for (int t = 0; t < 3000 && !(bidx == 1 && nbits == 3); t++) @(negedge i_clk);
      chk("t6_reached_bit4", int'(bidx == 1 && nbits == 3), 1);
      repeat (2 * QTR + 2) @(negedge i_clk);
      chk("t6_scl_low_before_reset", int'(o_scl_oe), 1);
      mon_en = 1'b0;
      w_start_rst = 1'b1;
      @(posedge i_clk);
      #1;
      chk("t6_reset_release", int'({o_scl_oe, o_sda_oe, o_busy}), 0);
      exp_q.delete();
      exp_done_q.delete();
      @(negedge i_clk);
      w_start_rst = 1'b0;
      repeat (5) @(negedge i_clk);
      mon_en = 1'b1;
      d = '{8'h96, 8'h00, 8'h00, 8'h00};
      run_txn(7'h47, 1, d, -1, dl, 0);
      for (int r = 0; r < 6; r++) begin
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : slave_addr;
         n = $urandom_range(1, 3);
         nk = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
         for (int k = 0; k < 4; k++) begin
            d[k] = 8'($urandom);
            dl[k] = $urandom_range(0, 10);
         end
         run_txn(a, n, d, nk, dl, 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end
endmodule

// File: doc/i2c_master_tx.md
Name: i2c_master_tx

Overview:
- Write-only I2C master that drives the far end of the bus our I2C slave receiver listens to.
- Generates START, the 7-bit address with R/W=0, checks each ACK, serialises data bytes taken from a valid/ready stream, then issues STOP.
- Runs on the system clock. SCL/SDA are open-drain pull-down enables.
- Intended as the loopback/stimulus partner for the slave and as the I2C side of the UART-to-I2C path.

Parameters:
- QTR_CYCLES, 125, system clocks per quarter SCL period (125 gives 100 kHz at 50 MHz); must be ≥2.
- CNT_W, $clog2(QTR_CYCLES), width of the quarter counter.

Ports:
- i_clk  in  1  system clock, rising edge.
- w_start_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  transaction request, sampled only in IDLE.
- i_addr  in  7  slave address, captured when i_start is accepted.
- i_tx_data  in  8  data byte.
- i_tx_last  in  1  marks the byte as the final one; captured with i_tx_data.
- i_tx_valid  in  1  byte available.
- o_tx_ready  out  1  master can accept a byte.
- i_sda_in  in  1  synchronised SDA line level, used for ACK.
- o_scl_oe  out  1  1 = pull SCL low.
- o_sda_oe  out  1  1 = pull SDA low.
- o_busy  out  1  transaction in progress.
- o_nack  out  1  sticky NACK flag; cleared when the next i_start is accepted.
- o_done  out  1  one-clock pulse at the end of STOP.

Behaviour:
- Reset values: all outputs 0, state IDLE, both lines released. Reset mid-operation releases both lines on the same edge without sending STOP.
- Bit timing: every SCL bit is 4 quarters Q0..Q3 of QTR_CYCLES clocks each.
  - Q0–Q1: SCL low. SDA is updated at the start of Q0.
  - Q2–Q3: SCL released.
  - SDA is sampled on the last clock of Q2.
  - No slave clock-stretch detection.
- States:
  - IDLE: both released, o_busy=0. On i_start: capture i_addr, clear o_nack, set o_busy next clock, go START.
  - START (one bit slot): Q0–Q1 both released; Q2 SDA low with SCL high; Q3 SCL low. Then ADDR.
  - ADDR: 8 bits, MSB first: i_addr[6:0] then 0 (write). 1 bit → sda_oe=0, 0 bit → sda_oe=1. Then ADDR_ACK.
  - ADDR_ACK: SDA released for the whole slot; sampled in Q2.
    - Sample 1: set o_nack, go STOP.
    - Sample 0: go LOAD.
  - LOAD: SCL held low, SDA held at its previous level, o_tx_ready=1. On i_tx_valid&&o_tx_ready: capture data and last, ready drops next clock, go DATA. No timeout while waiting.
  - DATA: 8 bits, MSB first. Then DATA_ACK.
  - DATA_ACK:
    - Sample 1: set o_nack, go STOP.
    - Captured last=1: go STOP.
    - Otherwise: go LOAD.
  - STOP: Q0 SDA low with SCL low; Q1 SCL released; Q2 SCL high with SDA low; Q3 SDA released.
    - On the last clock of Q3: o_done=1 for one clock; o_busy=0 from the next clock; go IDLE.
- i_start outside IDLE is ignored, not queued. i_start and reset together: reset wins.
- o_tx_ready is only ever 1 in LOAD. A byte presented elsewhere is not consumed.
- Bit counter: 3 bits, counts 7→0, wraps only on state change. Quarter counter reloads each quarter.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, START, ADDR, ADDR_ACK, LOAD, DATA, DATA_ACK, STOP);
  - 2-bit phase encoding Q0..Q3;
  - constant RW_WRITE=1'b0;
  - constant DEFAULT_DEVICE_ADDR=7'b1000111, shared with the slave.
- One sub-module, i2c_phase_gen:
  - quarter counter plus phase output and a one-clock phase_end strobe;
  - enable input freezes it in IDLE and LOAD.

Test Plan:
1. Hold reset, then release → all outputs 0, SCL/SDA released; no activity for 1000 clocks without i_start.
2. QTR_CYCLES=4, i_addr=7'h47, byte 8'hA5 with last=1, slave ACKs both → SDA sequence START, 1000111, 0, ACK, 10100101, ACK, STOP. SCL high time exactly 8 clocks; o_done one pulse; o_nack=0.
3. i_addr=7'h12, bus model leaves SDA high on the ACK slot → STOP immediately after ADDR_ACK; o_nack=1; o_tx_ready never asserted.
4. Two bytes 8'h3C then 8'hC3, second i_tx_valid delayed 37 clocks → SCL held low for the whole wait; both bytes serialised correctly; single STOP.
5. Three-byte write, slave NACKs byte 1; a second i_start is pulsed mid-byte → STOP after byte 1; o_nack=1; bytes 2–3 not consumed; the extra i_start is ignored.
6. Reset asserted during DATA bit 4 → next edge o_scl_oe=o_sda_oe=0 and o_busy=0; a fresh i_start then completes normally.
